// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial sequence detector.
// Compares the last LEN sampled bits of x against a loadable pattern with a
// per-bit don't-care mask, and keeps a saturating count of detections.
module seq_detector_prog #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic [LEN-1:0]   mask_in,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(LEN);
  localparam logic [FILL_W-1:0] FILL_THRESH = FILL_W'(LEN - 1);

  // Only the LEN-1 most recent bits are kept: together with the incoming x
  // they form the full LEN-bit window, and the oldest bit would be shifted out
  // before it could ever be compared again.
  logic [LEN-2:0]    hist;
  logic [FILL_W-1:0] fill;
  logic [LEN-1:0]    pat;
  logic [LEN-1:0]    mask;

  logic [LEN-1:0]    nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // Candidate window, saturating fill increment and the detection decision
  always_comb begin
    nxt      = {hist, x};
    fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    hit      = 1'b0;
    if (en && !pat_load && (fill >= FILL_THRESH))
      hit = ((nxt & mask) == (pat & mask));
  end

  // Pattern/mask registers, shift history, fill level and the match pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist  <= '0;
      fill  <= '0;
      pat   <= PATTERN;
      mask  <= '1;
      match <= 1'b0;
    end else if (pat_load) begin
      pat   <= pat_in;
      mask  <= mask_in;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (en) begin
      hist  <= nxt[LEN-2:0];
      match <= hit;
      if (!overlap && hit)
        fill <= '0;
      else
        fill <= fill_inc;
    end else begin
      match <= 1'b0;
    end
  end

  // Saturating match counter with sticky saturation flag; a clear wins over a hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clr_count) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (hit && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
      if ((match_count + CNT_W'(1)) == {CNT_W{1'b1}})
        count_sat <= 1'b1;
    end
  end

endmodule
